// File: rtl/nibble_serial_add_ctrl.sv
// ----------------------------------------------------------------------------
// nibble_serial_add_ctrl
//   Two-requester, round-robin arbitrated serial adder. Each accepted
//   operation is added 4 bits per cycle through one shared 4-bit ripple-carry
//   adder. The result is held in DONE until the consumer takes it.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   reqN_valid/a/b/cin  : requester N operation (N = 0, 1)
//   reqN_ready          : requester N accepted on this edge (combinational)
//   rsp_valid/rsp_ready : result handshake
//   rsp_sum, rsp_cout   : registered result (a + b + cin)
//   rsp_id              : requester that owns the result
//   busy                : controller not in IDLE
// ----------------------------------------------------------------------------

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// 4-bit ripple-carry adder: four chained full-adder cells.
module nib_add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] c;

    assign c[0] = cin;
    for (genvar i = 0; i < 4; i++) begin : g_fa
        full_adder u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
    end
    assign cout = c[4];
endmodule

module nibble_serial_add_ctrl #(
    parameter int N_NIB = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    input  logic [4*N_NIB-1:0] req0_a,
    input  logic [4*N_NIB-1:0] req0_b,
    input  logic               req0_cin,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [4*N_NIB-1:0] req1_a,
    input  logic [4*N_NIB-1:0] req1_b,
    input  logic               req1_cin,
    output logic               req1_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [4*N_NIB-1:0] rsp_sum,
    output logic               rsp_cout,
    output logic               rsp_id,
    output logic               busy
);
    localparam int IDX_W = (N_NIB > 1) ? $clog2(N_NIB) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t                  state, state_nxt;
    logic [N_NIB-1:0][3:0]   a_q, b_q, sum_q;
    logic [IDX_W-1:0]        idx;
    logic                    carry_q, cout_q, id_q;
    logic                    last_id;   // most recently granted requester
    logic                    gnt_id, accept, last_nib;
    logic [3:0]              nib_s;
    logic                    nib_co;

    // Tie goes to whoever was not granted last; a lone requester always wins.
    assign gnt_id     = (req0_valid && req1_valid) ? ~last_id : req1_valid;
    assign accept     = (state == IDLE) && !rst && (req0_valid || req1_valid);
    assign req0_ready = accept && !gnt_id;
    assign req1_ready = accept &&  gnt_id;
    assign last_nib   = (idx == IDX_W'(N_NIB - 1));

    // The one shared nibble adder; carry_q holds cin for nibble 0.
    nib_add4 u_add (
        .a    (a_q[idx]),
        .b    (b_q[idx]),
        .cin  (carry_q),
        .s    (nib_s),
        .cout (nib_co)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = ADD;
            ADD:     if (last_nib)  state_nxt = DONE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            id_q    <= 1'b0;
            last_id <= 1'b1;    // so requester 0 wins the first tie
        end else begin
            case (state)
                IDLE: if (accept) begin
                    a_q     <= gnt_id ? req1_a   : req0_a;
                    b_q     <= gnt_id ? req1_b   : req0_b;
                    carry_q <= gnt_id ? req1_cin : req0_cin;
                    id_q    <= gnt_id;
                    last_id <= gnt_id;
                    idx     <= '0;
                    sum_q   <= '0;
                end
                ADD: begin
                    sum_q[idx] <= nib_s;
                    carry_q    <= nib_co;
                    if (last_nib) begin
                        cout_q <= nib_co;
                        idx    <= '0;
                    end else begin
                        idx    <= idx + IDX_W'(1);
                    end
                end
                default: ;  // DONE: result frozen until consumed
            endcase
        end
    end

    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
    assign rsp_id    = id_q;

endmodule
